ysyx_23060201_isram: RTL

Synthesizable instruction-memory responder. It answers fetch requests from the core's PC/fetch stage over a valid/ready request/response handshake, with a configurable access latency. It returns the 32-bit word at the requested address, or an error for misaligned or out-of-range addresses. A separate load port lets the bench or boot logic fill the array. It replaces the zero-latency combinational instruction read so the fetch side can be built and verified against real wait states.

---
 rtl/ysyx_23060201_isram.sv | 95 +++++++++
 1 files changed

// File: rtl/ysyx_23060201_isram.sv
// Instruction-memory responder with valid/ready fetch handshake,
// configurable access latency and a side-band load port.
module ysyx_23060201_isram #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic        rd_err;
    logic [31:0] rd_data;

    assign req_ready = (state == S_IDLE);

    // Combinational read sees the pre-edge array, so a load landing on
    // the RESP-entry edge does not leak into the registered response.
    always_comb begin
        off     = addr_q - BASE;
        rd_err  = (addr_q[1:0] != 2'b00) || (off >= SPAN);
        rd_data = 32'h0;
        if (!rd_err) rd_data = mem[off[AW+1:2]];
    end

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    // cnt spans the full latency so resp_valid rises LATENCY edges
    // after the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'h0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= LAT;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt        <= 4'd0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= rd_data;
                        resp_err   <= rd_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
